// File: rtl/cpu_sim_run_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sim_run_monitor_if
//  Description : Bundle between the CPU under test and cpu_sim_run_monitor.
//                CPU-side observation signals flow into the monitor; reset
//                control, counters and the run verdict flow out of it.
//  Signals     : pc, retire, mem_we, mem_addr, mem_wdata   (CPU -> monitor)
//                cpu_rst, cycle_count, retire_count, done, pass, done_cause,
//                fail_code, final_pc                       (monitor -> bench)
//  Modports    : master - the monitor; slave - the CPU/bench side
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_sim_run_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  pc;
    logic             retire;
    logic             mem_we;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;

    logic             cpu_rst;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;
    logic             done;
    logic             pass;
    logic [1:0]       done_cause;
    logic [XLEN-1:0]  fail_code;
    logic [XLEN-1:0]  final_pc;

    modport master (
        input  pc, retire, mem_we, mem_addr, mem_wdata,
        output cpu_rst, cycle_count, retire_count, done, pass, done_cause,
               fail_code, final_pc
    );

    modport slave (
        output pc, retire, mem_we, mem_addr, mem_wdata,
        input  cpu_rst, cycle_count, retire_count, done, pass, done_cause,
               fail_code, final_pc
    );
endinterface
`default_nettype wire

// File: rtl/cpu_sim_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sim_run_monitor
//  Description : Simulation run controller/checker. Sequences the CPU reset,
//                counts RUN cycles and retired instructions, and ends the run
//                on a tohost store, a PC self-loop halt or a cycle budget
//                timeout. On completion the CPU is frozen in reset and a
//                sticky verdict is presented.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - cpu_sim_run_monitor_if.master (CPU observation in,
//                       cpu_rst / counters / verdict out)
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_sim_run_monitor #(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 32,
    parameter int              RST_CYCLES  = 2,
    parameter int              MAX_CYCLES  = 1000,
    parameter int              HALT_STABLE = 4,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    cpu_sim_run_monitor_if.master   bus
);

    localparam int HC_W = $clog2(RST_CYCLES) + 1;
    localparam int SB_W = $clog2(HALT_STABLE) + 1;

    localparam logic [1:0] c_st_hold = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [1:0] c_cause_tohost  = 2'd1;
    localparam logic [1:0] c_cause_halt    = 2'd2;
    localparam logic [1:0] c_cause_timeout = 2'd3;

    localparam logic [HC_W-1:0]  c_hold_last = HC_W'(RST_CYCLES - 1);
    localparam logic [SB_W-1:0]  c_halt_last = SB_W'(HALT_STABLE - 1);
    localparam logic [CNT_W-1:0] c_max_cyc   = CNT_W'(MAX_CYCLES);

    logic [1:0]       state_q,        state_d;
    logic [HC_W-1:0]  hold_cnt_q,     hold_cnt_d;
    logic             first_q,        first_d;
    logic [XLEN-1:0]  last_pc_q,      last_pc_d;
    logic [SB_W-1:0]  stab_q,         stab_d;
    logic [CNT_W-1:0] cycle_count_q,  cycle_count_d;
    logic [CNT_W-1:0] retire_count_q, retire_count_d;
    logic             done_q,         done_d;
    logic             pass_q,         pass_d;
    logic [1:0]       done_cause_q,   done_cause_d;
    logic [XLEN-1:0]  fail_code_q,    fail_code_d;
    logic [XLEN-1:0]  final_pc_q,     final_pc_d;

    logic w_tohost_hit;
    logic w_halt_hit;
    logic w_timeout_hit;

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        first_d        = first_q;
        last_pc_d      = last_pc_q;
        stab_d         = stab_q;
        cycle_count_d  = cycle_count_q;
        retire_count_d = retire_count_q;
        done_d         = done_q;
        pass_d         = pass_q;
        done_cause_d   = done_cause_q;
        fail_code_d    = fail_code_q;
        final_pc_d     = final_pc_q;
        w_tohost_hit   = 1'b0;
        w_halt_hit     = 1'b0;
        w_timeout_hit  = 1'b0;

        case (state_q)
            c_st_hold: begin
                if (hold_cnt_q == c_hold_last) begin
                    state_d = c_st_run;
                    // last_pc is stale on the first RUN edge; mask the compare.
                    first_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end

            c_st_run: begin
                first_d   = 1'b0;
                last_pc_d = bus.pc;

                cycle_count_d = (cycle_count_q == '1) ? cycle_count_q
                                                      : cycle_count_q + CNT_W'(1);
                if (bus.retire && (retire_count_q != '1)) begin
                    retire_count_d = retire_count_q + CNT_W'(1);
                end

                if (!first_q && (bus.pc == last_pc_q)) begin
                    stab_d = stab_q + SB_W'(1);
                end else begin
                    stab_d = '0;
                end

                w_tohost_hit  = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);
                w_halt_hit    = (stab_d == c_halt_last);
                w_timeout_hit = (cycle_count_d == c_max_cyc);

                // Priority: tohost > halt > timeout.
                if (w_tohost_hit) begin
                    done_cause_d = c_cause_tohost;
                    pass_d       = (bus.mem_wdata == XLEN'(1));
                    fail_code_d  = (bus.mem_wdata == XLEN'(1)) ? '0 : bus.mem_wdata;
                end else if (w_halt_hit) begin
                    done_cause_d = c_cause_halt;
                    pass_d       = 1'b0;
                end else if (w_timeout_hit) begin
                    done_cause_d = c_cause_timeout;
                    pass_d       = 1'b0;
                end

                if (w_tohost_hit || w_halt_hit || w_timeout_hit) begin
                    state_d    = c_st_done;
                    done_d     = 1'b1;
                    final_pc_d = bus.pc;
                end
            end

            default: begin
                // DONE: everything frozen until rst.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= c_st_hold;
            hold_cnt_q     <= '0;
            first_q        <= 1'b0;
            last_pc_q      <= '0;
            stab_q         <= '0;
            cycle_count_q  <= '0;
            retire_count_q <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            done_cause_q   <= 2'd0;
            fail_code_q    <= '0;
            final_pc_q     <= '0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            first_q        <= first_d;
            last_pc_q      <= last_pc_d;
            stab_q         <= stab_d;
            cycle_count_q  <= cycle_count_d;
            retire_count_q <= retire_count_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            done_cause_q   <= done_cause_d;
            fail_code_q    <= fail_code_d;
            final_pc_q     <= final_pc_d;
        end
    end

    // CPU is held in reset everywhere except RUN, which also freezes it on DONE.
    assign bus.cpu_rst      = (state_q != c_st_run);
    assign bus.cycle_count  = cycle_count_q;
    assign bus.retire_count = retire_count_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.done_cause   = done_cause_q;
    assign bus.fail_code    = fail_code_q;
    assign bus.final_pc     = final_pc_q;

endmodule
`default_nettype wire

// File: doc/cpu_sim_run_monitor.md
Name: cpu_sim_run_monitor

Overview:
- Parametrised run controller and checker that sits beside the CPU top in simulation benches.
- Sequences the CPU reset and counts cycles and retired instructions.
- Ends a run on one of three causes: a write to the tohost address, a PC self-loop halt, or a cycle-budget timeout.
- Freezes the CPU when the run ends and exposes a sticky pass/fail verdict, so benches stop relying on fixed delays and manual PC inspection.

Parameters:
XLEN, 32, width of pc, mem_addr, mem_wdata, fail_code, final_pc
CNT_W, 32, width of cycle_count and retire_count
RST_CYCLES, 2, cycles cpu_rst stays high after rst deasserts (>=1)
MAX_CYCLES, 1000, RUN-cycle budget before timeout (>=1)
HALT_STABLE, 4, consecutive RUN cycles with an unchanged pc that count as a halt (>=2)
TOHOST_ADDR, 32'h0000_1000, store address that ends the run

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pc  in  XLEN  current CPU program counter
retire  in  1  one instruction retired this cycle
mem_we  in  1  CPU data-memory write strobe
mem_addr  in  XLEN  CPU data-memory address
mem_wdata  in  XLEN  CPU data-memory write data
cpu_rst  out  1  reset driven to the CPU
cycle_count  out  CNT_W  RUN cycles elapsed
retire_count  out  CNT_W  instructions retired in RUN
done  out  1  run finished (sticky)
pass  out  1  run passed (valid when done=1)
done_cause  out  2  0 none, 1 tohost, 2 halt, 3 timeout
fail_code  out  XLEN  tohost data on fail, else 0
final_pc  out  XLEN  pc sampled on the done edge

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high; all state updates on the posedge of clk.
- Reset:
  - rst=1 at an edge: state=HOLD, hold_cnt=0, cpu_rst=1.
  - All counters, done, pass, done_cause, fail_code, final_pc and the stability counter clear to 0.
  - rst asserted mid-RUN or in DONE has the same effect at the next edge.
- States: HOLD -> RUN -> DONE. DONE is terminal until rst.
- HOLD:
  - cpu_rst=1. hold_cnt increments each edge with rst=0.
  - At the edge where hold_cnt reaches RST_CYCLES-1, go to RUN; cpu_rst drops to 0 on that same edge.
  - Net effect: cpu_rst is high for exactly RST_CYCLES edges after rst falls.
  - All CPU-side inputs are ignored in HOLD.
- RUN:
  - cycle_count increments every edge, saturating at all-ones.
  - retire_count increments on edges with retire=1, saturating.
  - Stability counter: pc is registered as last_pc. If pc==last_pc, stab increments; otherwise stab=0.
  - The last_pc comparison is disabled on the first RUN cycle.
- Done conditions, evaluated each RUN edge in priority order:
  1. mem_we=1 and mem_addr==TOHOST_ADDR: cause=1.
     - mem_wdata==1 gives pass=1, fail_code=0.
     - Any other value gives pass=0, fail_code=mem_wdata.
  2. stab reaches HALT_STABLE-1 (pc equal on HALT_STABLE consecutive samples): cause=2, pass=0.
  3. The edge on which cycle_count becomes MAX_CYCLES: cause=3, pass=0.
- On the done edge:
  - done=1, done_cause set, final_pc=pc (current input).
  - The counters include the done cycle's increment, including retire on that cycle.
  - cpu_rst=1 from that edge onward.
- DONE:
  - All outputs hold; counters freeze; further stores, pc changes and retires are ignored.
  - cpu_rst stays 1 to freeze the CPU.
- Simultaneous events: a tohost write on the same edge as a halt or timeout reports cause=1. Halt beats timeout.
- Widths: the count comparison against MAX_CYCLES is done at CNT_W bits. MAX_CYCLES must be <= 2^CNT_W-1.

Test Plan:
- Reset sequencing: rst high 3 cycles then low, RST_CYCLES=2 -> cpu_rst high for exactly 2 edges after rst falls, then 0; cycle_count=0 at the first RUN edge and 1 after it.
- Tohost pass: in RUN at cycle 10 drive mem_we=1, mem_addr=0x1000, mem_wdata=1, pc=0x40 -> done=1, pass=1, done_cause=1, fail_code=0, final_pc=0x40, cycle_count=10, cpu_rst=1; outputs hold for 20 further cycles.
- Tohost fail with a simultaneous halt: pc held at 0x24 for 4 cycles while a store of 0x7 to 0x1000 lands on the 4th -> done_cause=1, pass=0, fail_code=0x7.
- Halt loop: pc steps 0x0,0x4,0x8, then holds 0xC with HALT_STABLE=4 -> done on the 4th consecutive 0xC sample, done_cause=2, final_pc=0xC, pass=0; a store to 0x1000 afterwards is ignored.
- Timeout and counting: MAX_CYCLES=50, pc incrementing by 4, retire=1 every other cycle -> done on cycle 50 with done_cause=3, cycle_count=50, retire_count=25.
- Reset mid-run: assert rst at RUN cycle 7 -> the next edge gives done=0, counters=0, cpu_rst=1, state HOLD; the run then restarts correctly.
